// File: rtl/io_stream_array_mux.sv
// io_stream_array_mux: N_RD read channels plus one write channel share one
// single-port array, one access per cycle, under round-robin arbitration.
// Each read channel and the write acknowledge owns a one-entry response slot.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Valid
// never waits for ready. Ready may depend on valid in the same cycle. A slot's
// valid and payload stay stable until the transfer that consumes it.
module io_stream_array_mux #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int N_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    input  logic [N_RD-1:0]          rd_addr_valid,
    output logic [N_RD-1:0]          rd_addr_ready,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_data_valid,
    input  logic [N_RD-1:0]          rd_data_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     wr_addr_valid,
    output logic                     wr_addr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_data_valid,
    output logic                     wr_data_ready,
    output logic                     wr_ack_valid,
    input  logic                     wr_ack_ready
);
    localparam int NREQ = N_RD + 1;
    localparam int RR_W = $clog2(NREQ);
    localparam int MI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] slot [N_RD];
    logic [N_RD-1:0]   slot_v;
    logic              ack_v;
    logic [RR_W-1:0]   rr;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [RR_W-1:0]   gidx;
    logic              gfound;

    // Addresses at or above DEPTH never touch the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    function automatic logic [MI_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        return a[MI_W-1:0];
    endfunction

    // A requester may win only if its response slot is free or drains this cycle.
    always_comb begin
        elig = '0;
        if (!rst) begin
            for (int i = 0; i < N_RD; i++) begin
                elig[i] = rd_addr_valid[i] && (!slot_v[i] || rd_data_ready[i]);
            end
            elig[N_RD] = wr_addr_valid && wr_data_valid && (!ack_v || wr_ack_ready);
        end
    end

    // Round-robin scan from rr, wrapping over all NREQ requesters.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        gidx   = '0;
        gfound = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!gfound && elig[idx]) begin
                grant[idx] = 1'b1;
                gidx       = RR_W'(idx);
                gfound     = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (gfound) begin
            rr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    // Array write port; out-of-range writes are dropped. Contents survive reset.
    always_ff @(posedge clk) begin
        if (grant[N_RD] && in_range(wr_addr)) begin
            mem[mem_idx(wr_addr)] <= wr_data;
        end
    end

    // Read response slots: load on grant, clear on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v <= '0;
            for (int i = 0; i < N_RD; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                if (grant[i]) begin
                    slot_v[i] <= 1'b1;
                    slot[i]   <= in_range(rd_addr[i*ADDR_W +: ADDR_W])
                                 ? mem[mem_idx(rd_addr[i*ADDR_W +: ADDR_W])] : '0;
                end else if (rd_data_ready[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    // Write acknowledge slot, set for every granted write including dropped ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_v <= 1'b0;
        end else if (grant[N_RD]) begin
            ack_v <= 1'b1;
        end else if (wr_ack_ready) begin
            ack_v <= 1'b0;
        end
    end

    // Pack per-channel slots onto the flat response bus.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = slot[i];
        end
    end

    assign rd_addr_ready = grant[N_RD-1:0];
    assign wr_addr_ready = grant[N_RD];
    assign wr_data_ready = grant[N_RD];
    assign rd_data_valid = slot_v;
    assign wr_ack_valid  = ack_v;

endmodule

// File: tb/tb_io_stream_array_mux.sv
// Bench for io_stream_array_mux with two read channels and a 200-word array.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_io_stream_array_mux;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int N_RD   = 2;
    localparam int NREQ   = N_RD + 1;

    logic                   clk;
    logic                   rst;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_addr_valid;
    logic [N_RD-1:0]        rd_addr_ready;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_data_valid;
    logic [N_RD-1:0]        rd_data_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   wr_addr_valid;
    logic                   wr_addr_ready;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_data_valid;
    logic                   wr_data_ready;
    logic                   wr_ack_valid;
    logic                   wr_ack_ready;

    io_stream_array_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_RD(N_RD)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .wr_addr(wr_addr), .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_ack_valid(wr_ack_valid), .wr_ack_ready(wr_ack_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [N_RD][$];
    logic              m_ack;
    int                m_ptr;

    // last sampled DUT view
    logic [NREQ-1:0]        last_dut_g;
    logic [NREQ-1:0]        last_exp_g;
    logic [N_RD*DATA_W-1:0] last_rd_data;
    logic [N_RD-1:0]        last_rd_v;
    logic                   last_ack;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next winner: first eligible requester scanning from the pointer.
    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] el;
        logic [NREQ-1:0] g;
        int idx;
        g = '0;
        if (rst) return g;
        for (int i = 0; i < N_RD; i++)
            el[i] = rd_addr_valid[i] && (exp_q[i].size() == 0 || rd_data_ready[i]);
        el[N_RD] = wr_addr_valid && wr_data_valid && (!m_ack || wr_ack_ready);
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (el[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // scoreboard: check one cycle, advance the model, move to next falling edge
    task automatic step();
        logic [NREQ-1:0]   eg;
        logic [ADDR_W-1:0] a;
        #1;
        last_dut_g   = {wr_addr_ready, rd_addr_ready};
        last_rd_v    = rd_data_valid;
        last_rd_data = rd_data;
        last_ack     = wr_ack_valid;
        for (int i = 0; i < N_RD; i++) begin
            chk($sformatf("rd_valid%0d", i), 32'(rd_data_valid[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0)
                chk($sformatf("rd_data%0d", i), 32'(rd_data[i*DATA_W +: DATA_W]), 32'(exp_q[i][0]));
        end
        chk("ack_valid", 32'(wr_ack_valid), 32'(m_ack));
        eg = model_grant();
        chk("grant", 32'(last_dut_g), 32'(eg));
        chk("wr_data_ready", 32'(wr_data_ready), 32'(eg[N_RD]));
        last_exp_g = eg;
        if (rst) begin
            for (int i = 0; i < N_RD; i++) exp_q[i].delete();
            m_ack = 1'b0;
            m_ptr = 0;
        end else begin
            for (int i = 0; i < N_RD; i++)
                if (exp_q[i].size() != 0 && rd_data_ready[i]) void'(exp_q[i].pop_front());
            if (m_ack && wr_ack_ready) m_ack = 1'b0;
            for (int r = 0; r < NREQ; r++) begin
                if (eg[r]) begin
                    if (r < N_RD) begin
                        a = rd_addr[r*ADDR_W +: ADDR_W];
                        exp_q[r].push_back((int'(a) < DEPTH) ? m_mem[a] : '0);
                    end else begin
                        if (int'(wr_addr) < DEPTH) m_mem[wr_addr] = wr_data;
                        m_ack = 1'b1;
                    end
                    m_ptr = (r + 1) % NREQ;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // drivers
    task automatic set_idle();
        rd_addr_valid = '0;
        wr_addr_valid = 1'b0;
        wr_data_valid = 1'b0;
        rd_data_ready = '1;
        wr_ack_ready  = 1'b1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic ok;
        ok = 1'b0;
        wr_addr = a; wr_data = d;
        wr_addr_valid = 1'b1; wr_data_valid = 1'b1;
        for (int t = 0; t < 16 && !ok; t++) begin
            step();
            ok = last_exp_g[N_RD];
        end
        wr_addr_valid = 1'b0; wr_data_valid = 1'b0;
        if (!ok) chk("wr_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input int ch, input logic [ADDR_W-1:0] a);
        logic ok;
        ok = 1'b0;
        rd_addr[ch*ADDR_W +: ADDR_W] = a;
        rd_addr_valid[ch] = 1'b1;
        for (int t = 0; t < 16 && !ok; t++) begin
            step();
            ok = last_exp_g[ch];
        end
        rd_addr_valid[ch] = 1'b0;
        if (!ok) chk("rd_grant_timeout", 32'd0, 32'd1);
    endtask

    logic [DATA_W-1:0] v0, v199, vbp;

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        set_idle();
        m_ack = 1'b0; m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(negedge clk);
        step();
        step();
        chk("reset_rd_data", 32'(last_rd_data), 32'd0);
        chk("reset_valids", 32'({last_ack, last_rd_v}), 32'd0);
        rst = 1'b0;

        // fill the whole array with random words
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'($urandom));

        // write i*7 to 0..7, read back on channel 0
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), DATA_W'(i * 7));
        step();
        for (int i = 0; i < 8; i++) begin
            do_read(0, ADDR_W'(i));
            step();
            chk($sformatf("seq_rd%0d", i), 32'(last_rd_data[DATA_W-1:0]), 32'(i * 7));
        end

        // fairness from reset: all three requesters held valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_addr = {8'd20, 8'd10};
        wr_addr = 8'd30; wr_data = 8'h3C;
        rd_addr_valid = '1; wr_addr_valid = 1'b1; wr_data_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("fair%0d", k), 32'(last_dut_g), 32'(1 << (k % 3)));
        end
        set_idle();
        step();

        // back-pressure on channel 0 must not stall channel 1
        rd_data_ready[0] = 1'b0;
        do_read(0, 8'd5);
        vbp = m_mem[5];
        rd_addr_valid = '1;
        rd_addr[7:0] = 8'd6;
        for (int k = 0; k < 6; k++) begin
            rd_addr[15:8] = ADDR_W'(10 + k);
            step();
            chk("bp_rd0_ready", 32'(last_dut_g[0]), 32'd0);
            chk("bp_rd0_data", 32'(last_rd_data[7:0]), 32'(vbp));
            if (k > 0) chk("bp_rd1_valid", 32'(last_rd_v[1]), 32'd1);
        end
        set_idle();
        step();
        step();

        // out-of-range write is acknowledged but dropped; reads return 0
        v0 = m_mem[0]; v199 = m_mem[199];
        do_write(8'd210, 8'hAB);
        step();
        chk("oob_ack", 32'(last_ack), 32'd1);
        do_read(0, 8'd210);
        step();
        chk("oob_rd", 32'(last_rd_data[7:0]), 32'd0);
        do_read(0, 8'd199);
        step();
        chk("keep199", 32'(last_rd_data[7:0]), 32'(v199));
        do_read(1, 8'd0);
        step();
        chk("keep0", 32'(last_rd_data[15:8]), 32'(v0));

        // read granted the cycle after a write to the same address sees new data
        do_write(8'd3, 8'h55);
        do_read(0, 8'd3);
        chk("raw_grant_next", 32'(last_dut_g), 32'd1);
        step();
        chk("raw_data", 32'(last_rd_data[7:0]), 32'h55);

        // reset while responses are pending
        rd_data_ready = '0; wr_ack_ready = 1'b0;
        do_read(0, 8'd1);
        do_read(1, 8'd2);
        do_write(8'd4, DATA_W'($urandom));
        rd_addr_valid = '1; wr_addr_valid = 1'b1; wr_data_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_valids", 32'({last_ack, last_rd_v}), 32'd0);
        chk("post_rst_grant", 32'(last_dut_g), 32'd1);
        set_idle();
        step();
        step();

        // random traffic, including lone write address or data
        for (int k = 0; k < 400; k++) begin
            rd_addr_valid = N_RD'($urandom_range(0, 3));
            rd_addr       = {ADDR_W'($urandom_range(0, 219)), ADDR_W'($urandom_range(0, 219))};
            wr_addr_valid = 1'($urandom_range(0, 1));
            wr_data_valid = 1'($urandom_range(0, 1));
            wr_addr       = ADDR_W'($urandom_range(0, 219));
            wr_data       = DATA_W'($urandom);
            rd_data_ready = N_RD'($urandom_range(0, 3));
            wr_ack_ready  = 1'($urandom_range(0, 1));
            step();
        end
        set_idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
